light_conflict_monitor: RTL

- Safety stage directly downstream of the traffic light controller.
- Consumes the controller's four 3-bit light codes (M1, S, MT, M2) and registers them onto the lamp-drive outputs.
- Continuously checks for illegal codes, conflicting right-of-way and bad amber sequencing.
- On any violation it latches a fault code and forces all lamps to flashing red until a qualified clear.

---
 rtl/light_conflict_monitor.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/light_conflict_monitor.sv
// Safety stage behind the traffic light controller: registers the four light codes
// onto the lamps and forces flashing red on illegal codes, conflicts or bad amber.
module light_conflict_monitor #(
    parameter int MIN_YELLOW  = 3,
    parameter int STARTUP_CYC = 4,
    parameter int FLASH_HALF  = 2,
    parameter int ALLRED_CLR  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] in_M1,
    input  logic [2:0] in_S,
    input  logic [2:0] in_MT,
    input  logic [2:0] in_M2,
    input  logic       fault_clr,
    output logic [2:0] lamp_M1,
    output logic [2:0] lamp_S,
    output logic [2:0] lamp_MT,
    output logic [2:0] lamp_M2,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] state_o
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam int AW = $clog2(ALLRED_CLR + 1);
    localparam int SW = $clog2(STARTUP_CYC + 1);
    localparam int FW = $clog2(FLASH_HALF + 1);

    // Direction index: 0 = M1, 1 = S, 2 = MT, 3 = M2
    localparam int D_M1 = 0;
    localparam int D_S  = 1;
    localparam int D_MT = 2;
    localparam int D_M2 = 3;

    typedef enum logic [1:0] {
        ST_STARTUP = 2'd0,
        ST_NORMAL  = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [3:0][2:0]   cur;
    logic [3:0][2:0]   prev;
    logic [3:0][2:0]   lamps;
    logic [3:0][2:0]   lamps_next;
    logic [YW-1:0]     ycnt [4];
    logic [AW-1:0]     allred_cnt;
    logic [SW-1:0]     startup_cnt;
    logic [SW-1:0]     startup_cnt_next;
    logic [FW-1:0]     flash_cnt;
    logic [FW-1:0]     flash_cnt_next;
    logic              flash_phase;
    logic              flash_phase_next;
    logic              fault_q;
    logic              fault_next;
    logic [2:0]        code_q;
    logic [2:0]        code_next;

    logic [3:0]        active;
    logic              illegal;
    logic              conflict;
    logic              skip_amber;
    logic              short_amber;
    logic [2:0]        viol_code;
    logic              violation;
    logic              all_red_now;
    logic              clr_ok;

    assign cur = {in_M2, in_MT, in_S, in_M1};

    // Per-direction rule evaluation against the previous sample
    always_comb begin
        active      = '0;
        illegal     = 1'b0;
        skip_amber  = 1'b0;
        short_amber = 1'b0;
        for (int i = 0; i < 4; i++) begin
            active[i] = (cur[i] == YEL) || (cur[i] == GRN);
            if (!((cur[i] == RED) || (cur[i] == YEL) || (cur[i] == GRN))) begin
                illegal = 1'b1;
            end
            if ((prev[i] == GRN) && (cur[i] == RED)) begin
                skip_amber = 1'b1;
            end
            if ((prev[i] == YEL) && (cur[i] == RED) && (ycnt[i] < YW'(MIN_YELLOW))) begin
                short_amber = 1'b1;
            end
        end
        conflict = (active[D_S]  & active[D_M1]) |
                   (active[D_S]  & active[D_M2]) |
                   (active[D_S]  & active[D_MT]) |
                   (active[D_M2] & active[D_MT]);
    end

    always_comb begin
        viol_code = 3'd0;
        if (illegal) begin
            viol_code = 3'd1;
        end else if (conflict) begin
            viol_code = 3'd2;
        end else if (skip_amber) begin
            viol_code = 3'd3;
        end else if (short_amber) begin
            viol_code = 3'd4;
        end
    end

    assign violation   = (viol_code != 3'd0);
    assign all_red_now = (cur == {4{RED}});
    // The all-red history must be complete before this edge's clear request
    assign clr_ok      = fault_clr && (allred_cnt == AW'(ALLRED_CLR));

    always_comb begin
        state_next       = state;
        lamps_next       = lamps;
        fault_next       = fault_q;
        code_next        = code_q;
        startup_cnt_next = startup_cnt;
        flash_cnt_next   = flash_cnt;
        flash_phase_next = flash_phase;
        case (state)
            ST_STARTUP: begin
                lamps_next = {4{RED}};
                if (startup_cnt == SW'(STARTUP_CYC - 1)) begin
                    state_next = ST_NORMAL;
                end else begin
                    startup_cnt_next = startup_cnt + SW'(1);
                end
            end
            ST_NORMAL: begin
                if (violation) begin
                    state_next       = ST_FAULT;
                    fault_next       = 1'b1;
                    code_next        = viol_code;
                    lamps_next       = {4{RED}};
                    flash_phase_next = 1'b1;
                    flash_cnt_next   = '0;
                end else begin
                    lamps_next = cur;
                end
            end
            ST_FAULT: begin
                if (clr_ok) begin
                    state_next = ST_NORMAL;
                    fault_next = 1'b0;
                    code_next  = 3'd0;
                    lamps_next = cur;
                end else begin
                    if (flash_cnt == FW'(FLASH_HALF - 1)) begin
                        flash_phase_next = ~flash_phase;
                        flash_cnt_next   = '0;
                    end else begin
                        flash_cnt_next = flash_cnt + FW'(1);
                    end
                    lamps_next = {4{flash_phase_next, 2'b00}};
                end
            end
            default: begin
                state_next = ST_STARTUP;
                lamps_next = {4{RED}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_STARTUP;
            lamps       <= {4{RED}};
            fault_q     <= 1'b0;
            code_q      <= 3'd0;
            startup_cnt <= '0;
            flash_cnt   <= '0;
            flash_phase <= 1'b1;
            prev        <= {4{RED}};
            allred_cnt  <= '0;
            for (int i = 0; i < 4; i++) begin
                ycnt[i] <= '0;
            end
        end else begin
            state       <= state_next;
            lamps       <= lamps_next;
            fault_q     <= fault_next;
            code_q      <= code_next;
            startup_cnt <= startup_cnt_next;
            flash_cnt   <= flash_cnt_next;
            flash_phase <= flash_phase_next;
            prev        <= cur;
            for (int i = 0; i < 4; i++) begin
                if (cur[i] != YEL) begin
                    ycnt[i] <= '0;
                end else if (ycnt[i] != YW'(MIN_YELLOW)) begin
                    ycnt[i] <= ycnt[i] + YW'(1);
                end
            end
            if (!all_red_now) begin
                allred_cnt <= '0;
            end else if (allred_cnt != AW'(ALLRED_CLR)) begin
                allred_cnt <= allred_cnt + AW'(1);
            end
        end
    end

    assign lamp_M1    = lamps[D_M1];
    assign lamp_S     = lamps[D_S];
    assign lamp_MT    = lamps[D_MT];
    assign lamp_M2    = lamps[D_M2];
    assign fault      = fault_q;
    assign fault_code = code_q;
    assign state_o    = state;

endmodule
